// File: rtl/newton_pkg.sv
// Shared constants, FSM encoding and the 1/sqrt seed table for the Newton-Raphson square root.
// Fixed-point formats: radicand 0.32, iterate 2.32.
package newton_pkg;

  localparam int NR_ITER = 3;
  localparam int FRAC_W  = 32;
  localparam int X_W     = 34;
  localparam int ROM_AW  = 4;
  localparam int ROM_DW  = 8;

  // Fraction bits of 1/sqrt(d) at each bucket midpoint, rounded to nearest. Buckets whose range
  // reaches 1/sqrt(d) >= 2.0 (everything up to and including d = 0.25) saturate to all ones.
  localparam logic [ROM_DW-1:0] RSQRT_TABLE [0:(1<<ROM_AW)-1] = '{
    8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hB5, 8'h92, 8'h76,
    8'h5F, 8'h4C, 8'h3C, 8'h2E, 8'h22, 8'h17, 8'h0D, 8'h04
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rsqrt_rom.sv
// Combinational 1/sqrt seed lookup indexed by the top radicand bits; no clock, no reset.
module rsqrt_rom
  import newton_pkg::*;
(
  input  logic [ROM_AW-1:0] addr,
  output logic [ROM_DW-1:0] data
);

  assign data = RSQRT_TABLE[addr];

endmodule

// File: rtl/newton_sqrt.sv
// Square root via three Newton-Raphson reciprocal-sqrt iterations, one per clock; ready rises
// 3 clocks after the last start edge and holds. No backpressure: start always reloads/aborts.
module newton_sqrt
  import newton_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic [FRAC_W-1:0] d,
  input  logic              start,
  output logic [FRAC_W-1:0] q,
  output logic              busy,
  output logic              ready,
  output logic              err,
  output logic [1:0]        count
);

  localparam logic [X_W-1:0] THREE = {2'b11, {FRAC_W{1'b0}}};
  localparam logic [1:0]     LAST  = 2'(NR_ITER - 1);

  state_t                  state, state_nxt;
  logic [FRAC_W-1:0]       reg_d;
  logic [X_W-1:0]          reg_x, x0, s, t, y, x_next;
  logic [ROM_DW-1:0]       seed;
  logic [2*X_W-1:0]        sq, p;
  logic [FRAC_W+X_W-1:0]   td, m;
  logic [FRAC_W:0]         q_rnd;

  rsqrt_rom u_rom (
    .addr (d[FRAC_W-1 -: ROM_AW]),
    .data (seed)
  );

  assign x0 = {2'b01, seed, {(FRAC_W-ROM_DW){1'b0}}};

  // One iteration x' = x * (3 - d*x^2) / 2, every product truncated back to 2.32.
  assign sq     = {{X_W{1'b0}}, reg_x} * {{X_W{1'b0}}, reg_x};
  assign s      = X_W'(sq >> FRAC_W);
  assign td     = {{X_W{1'b0}}, reg_d} * {{FRAC_W{1'b0}}, s};
  assign t      = X_W'(td >> FRAC_W);
  assign y      = THREE - t;
  assign p      = {{X_W{1'b0}}, reg_x} * {{X_W{1'b0}}, y};
  assign x_next = X_W'(p >> (FRAC_W + 1));

  // sqrt(d) = d * rsqrt(d); round up on any of the three guard bits, saturate on overflow.
  assign m     = {{X_W{1'b0}}, reg_d} * {{FRAC_W{1'b0}}, reg_x};
  assign q_rnd = {1'b0, m[2*FRAC_W-1:FRAC_W]}
               + (FRAC_W+1)'(|(m[FRAC_W-1:0] >> (FRAC_W - 3)));

  always_comb begin
    q = q_rnd[FRAC_W-1:0];
    if (err) begin
      q = '0;
    end else if ((|m[FRAC_W+X_W-1:2*FRAC_W]) || q_rnd[FRAC_W]) begin
      q = '1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = ST_BUSY;
    end else if (state == ST_BUSY && count == LAST) begin
      state_nxt = ST_DONE;
    end
  end

  assign busy  = (state == ST_BUSY);
  assign ready = (state == ST_DONE);

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      reg_d <= '0;
      reg_x <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (start) begin
      reg_d <= d;
      reg_x <= x0;
      count <= '0;
      err   <= (d[FRAC_W-1:FRAC_W-2] == 2'b00);
    end else if (busy) begin
      reg_x <= x_next;
      count <= count + 2'd1;
    end
  end

endmodule

// File: tb/tb_newton_sqrt.sv
// Randomized scoreboard bench for newton_sqrt against a fixed-point reference model.
module tb_newton_sqrt;

  logic        clk   = 1'b0;
  logic        clrn  = 1'b0;
  logic [31:0] d     = '0;
  logic        start = 1'b0;
  logic [31:0] q;
  logic        busy, ready, err;
  logic [1:0]  count;

  newton_sqrt dut (
    .clk   (clk),
    .clrn  (clrn),
    .d     (d),
    .start (start),
    .q     (q),
    .busy  (busy),
    .ready (ready),
    .err   (err),
    .count (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic        err;
    bit          tol;
    logic [31:0] gold;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Seed: 1/sqrt at the bucket midpoint, saturated when the bucket reaches 1/sqrt(d) >= 2.0.
  function automatic logic [7:0] seed_frac(input int a);
    real lo, mid;
    if (a == 0) return 8'hFF;
    lo = a / 16.0;
    if (1.0 / $sqrt(lo) >= 2.0) return 8'hFF;
    mid = (a + 0.5) / 16.0;
    return 8'($rtoi((1.0 / $sqrt(mid) - 1.0) * 256.0 + 0.5));
  endfunction

  // Fixed-point Newton-Raphson using wide integer arithmetic on 2.32 values.
  function automatic logic [31:0] model_q(input logic [31:0] dv);
    logic [127:0] mask34, x, dd, s, t, y, mm, r;
    mask34 = (128'd1 << 34) - 128'd1;
    x  = (128'd1 << 32) + (128'(seed_frac(int'(dv[31:28]))) << 24);
    dd = 128'(dv);
    for (int i = 0; i < 3; i++) begin
      s = ((x * x) >> 32) & mask34;
      t = ((dd * s) >> 32) & mask34;
      y = ((128'd3 << 32) - t) & mask34;
      x = ((x * y) >> 33) & mask34;
    end
    if (dv[31:30] == 2'b00) return 32'h0;
    mm = dd * x;
    if (mm >= (128'd1 << 64)) return 32'hFFFF_FFFF;
    r = (mm >> 32) + (((mm & 128'hE000_0000) != 0) ? 128'd1 : 128'd0);
    if (r > 128'hFFFF_FFFF) return 32'hFFFF_FFFF;
    return 32'(r);
  endfunction

  // Called just after a falling edge; leaves start low for `gap` edges after the load edge.
  task automatic issue(input logic [31:0] dv, input int gap, input bit tol, input logic [31:0] gold);
    exp_t e;
    d     = dv;
    start = 1'b1;
    if (gap >= 3) begin
      e.q    = model_q(dv);
      e.err  = (dv[31:30] == 2'b00);
      e.tol  = tol;
      e.gold = gold;
      sb.push_back(e);
    end
    @(negedge clk);
    chk("busy_after_start", 64'(busy), 64'd1);
    chk("ready_after_start", 64'(ready), 64'd0);
    chk("count_after_start", 64'(count), 64'd0);
    #1;
    if (gap > 0) begin
      start = 1'b0;
      repeat (gap) @(negedge clk);
      #1;
    end
  endtask

  // Monitor: pops an expectation on each rising ready and checks latency and result.
  initial begin
    int          since = 15;
    bit          rdy_q = 1'b0;
    logic [31:0] held  = '0;
    logic [31:0] diff;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (start) since = 0;
      else if (since < 15) since++;
      if (ready && !rdy_q) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ready: ready rose with q=%0h, no result outstanding", q);
        end else begin
          e = sb.pop_front();
          chk("latency", 64'(since), 64'd3);
          chk("q", 64'(q), 64'(e.q));
          chk("err", 64'(err), 64'(e.err));
          chk("busy_at_ready", 64'(busy), 64'd0);
          chk("count_at_ready", 64'(count), 64'd3);
          if (e.tol) begin
            diff = (q > e.gold) ? q - e.gold : e.gold - q;
            total++;
            if (diff > 32'd2) begin
              bad++;
              $display("FAIL q_accuracy: got %0h, expected %0h +/-2", q, e.gold);
            end
          end
          held = e.q;
        end
      end else if (ready && rdy_q) begin
        chk("q_held", 64'(q), 64'(held));
      end
      rdy_q = ready;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, outstanding=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] dv;
    int          gap;

    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_q", 64'(q), 64'd0);
    #1 clrn = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_ready", 64'(ready), 64'd0);
    #1;

    issue(32'h4000_0000, 4, 1'b1, 32'h8000_0000);
    issue(32'h8000_0000, 5, 1'b1, 32'hB504_F334);
    issue(32'hFFFF_FFFF, 3, 1'b1, 32'hFFFF_FFFF);
    issue(32'h2000_0000, 3, 1'b1, 32'h0000_0000);
    issue(32'h4FFF_FFFF, 3, 1'b0, 32'h0);
    issue(32'h5000_0000, 3, 1'b0, 32'h0);

    // Restart one clock after a start: only the second radicand may produce a result.
    issue(32'h4000_0000, 1, 1'b0, 32'h0);
    issue(32'h8000_0000, 4, 1'b1, 32'hB504_F334);

    // Start held high across several edges with changing radicands.
    issue(32'h1234_5678, 0, 1'b0, 32'h0);
    issue(32'h9ABC_DEF0, 0, 1'b0, 32'h0);
    issue(32'hC000_0000, 4, 1'b0, 32'h0);

    // Reset mid-computation on an out-of-range radicand.
    d = 32'h1000_0000;
    start = 1'b1;
    @(negedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    #1 clrn = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'(ready), 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_q", 64'(q), 64'd0);
    @(negedge clk);
    #1 clrn = 1'b1;
    #1;

    // Reset while a valid result is being presented.
    issue(32'hB000_0000, 4, 1'b0, 32'h0);
    clrn = 1'b0;
    #1;
    chk("rdyrst_ready", 64'(ready), 64'd0);
    chk("rdyrst_q", 64'(q), 64'd0);
    @(negedge clk);
    #1 clrn = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_ready", 64'(ready), 64'd0);
    chk("post_rst_busy", 64'(busy), 64'd0);
    #1;

    for (int i = 0; i < 40; i++) begin
      dv = $urandom;
      if ($urandom_range(0, 7) == 0) dv[31:30] = 2'b00;
      else if (dv[31:30] == 2'b00) dv[31:30] = 2'b01;
      gap = $urandom_range(0, 6);
      issue(dv, gap, 1'b0, 32'h0);
    end
    dv = $urandom | 32'h4000_0000;
    issue(dv, 4, 1'b0, 32'h0);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    chk("drain_outstanding", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/newton_sqrt.md
NEWTON_SQRT -- requirements
Module: newton_sqrt

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clk, input, 1: clock; all state updates on the rising edge.
- clrn, input, 1: reset; asynchronous, active-low.
- d, input, 32: radicand, unsigned fraction .xxxx…x; valid range [0.25, 1), so d[31:30] != 2'b00.
- start, input, 1: load d and begin a computation; sampled on the rising edge of clk.
- q, output, 32: square root, fraction .1xxx…x.
- busy, output, 1: computation in progress.
- ready, output, 1: q is valid.
- err, output, 1: the radicand captured at the last start was out of range.
- count, output, 2: iteration counter.

Function
REQ-002 The algorithm SHALL be Newton-Raphson on the reciprocal square root, x(i+1) = x(i)·(3 − d·x(i)²)/2, followed by q = d·x(3).
REQ-003 The seed SHALL be x0 = {2'b01, rom(d[31:28]), 24'b0} in 2.32 format. rom is an 8-bit table returning the fraction of 1/sqrt at the bucket midpoint. rom saturates to 8'hFF for buckets whose true value is ≥ 2.0.
REQ-004 The start edge SHALL capture d into reg_d and x0 into reg_x (34 bits, 2.32). On that edge: busy←1, ready←0, count←0, err←(d[31:30]==2'b00).
REQ-005 On each edge with busy=1 and start=0, the block SHALL perform one iteration and increment count.
REQ-006 The datapath widths per iteration SHALL be:
- s = reg_x², a 68-bit product truncated to 2.32.
- t = reg_d·s, truncated to 2.32.
- y = 3.0 − t, in 2.32, computed modulo 2^34.
- p = reg_x·y, 68 bits; reg_x ← p[66:33], which is the product divided by 2, in 2.32.
REQ-007 On the edge where count==2 and busy=1, the block SHALL perform the third iteration, then set busy←0 and ready←1, with count wrapping to 3.
REQ-008 Latency: ready SHALL first be high exactly 3 clocks after the start edge.
REQ-009 Once set, ready SHALL hold until the next start or reset.
REQ-010 While busy=0 and start=0, all registers SHALL hold their values.
REQ-011 q SHALL be combinational from reg_d·reg_x (66-bit product m), as follows:
- If m[65:64] != 0, q = 32'hFFFF_FFFF (saturate).
- Otherwise q = m[63:32] + |m[31:29] (round up), also saturating at 32'hFFFF_FFFF.
REQ-012 When err=1, q SHALL read 32'h0000_0000. The rest of the sequence and its timing are unchanged.
REQ-013 start asserted while busy=1 SHALL abort the current computation and restart from the new d, with identical behaviour to REQ-004.
REQ-014 start held high for several cycles SHALL reload every cycle. The 3-cycle latency counts from the last edge at which start is high.
REQ-015 A start coinciding with ready=1 SHALL clear ready on that edge.
REQ-016 q is guaranteed only while ready=1. While busy=1, q is don't-care.

Reset
REQ-017 When clrn is low, the block SHALL immediately set busy=0, ready=0, err=0, count=0, reg_d=0 and reg_x=0. As a result, q=0.
REQ-018 Reset asserted mid-computation SHALL abandon that computation.
REQ-019 After clrn deasserts, the block SHALL stay idle until the next start edge.
REQ-020 The block SHALL leave the rom contents unaffected by reset.

Structure
REQ-021 A shared package newton_pkg SHALL hold the following constants:
- NR_ITER = 3
- FRAC_W = 32
- X_W = 34
- ROM_AW = 4
- ROM_DW = 8
- the rom contents table
REQ-022 The seed table SHALL be a separate combinational sub-module, rsqrt_rom, with a 4-bit address and 8-bit data.
REQ-023 The iteration datapath SHALL be purely combinational between reg_x/reg_d and the next reg_x, with no pipeline registers. One iteration completes per clock.

Verification
REQ-024 d=32'h4000_0000 (0.25), start for 1 cycle → busy rises next edge; ready=1 after 3 clocks; q=32'h8000_0000 ±2 LSB; err=0; count=3.
REQ-025 d=32'h8000_0000 (0.5) → q=32'hB504_F334 ±2 LSB at ready; busy=0.
REQ-026 d=32'hFFFF_FFFF → q within 2 LSB of 32'hFFFF_FFFF with no wrap to small values, i.e. saturation is checked.
REQ-027 d=32'h2000_0000 (out of range) → err=1, q=0, ready after 3 clocks.
REQ-028 Start d=0.25, then start d=0.5 after 1 clock → ready 3 clocks after the second start; q=32'hB504_F334 ±2; ready never pulses in between.
REQ-029 clrn pulsed low mid-computation → busy=ready=err=0 and q=0 immediately; no ready afterwards until a new start.
